// File: rtl/fifo_rd_ctrl.sv
// Packet read controller: locks onto the FIFO named by the held selection code and
// moves one packet through a registered ready/valid stage. Optional packet counter: FIFO_RD_CTRL_STAT_EN.
module fifo_rd_ctrl #(
  parameter int PORT_NUM  = 8,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic                         glb_clk,
  input  logic                         glb_rst,
  input  logic [7:0]                   fifo_sel_res_final,
  input  logic [PORT_NUM-1:0]          fifo_empty,
  input  logic [PORT_NUM*DATA_W-1:0]   fifo_rd_data,
  input  logic [PORT_NUM-1:0]          fifo_rd_eop,
  output logic [PORT_NUM-1:0]          fifo_rd_en,
  output logic [PORT_NUM-1:0]          fifo_ack,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_eop,
  output logic [2:0]                   out_port,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         trunc_err,
  output logic [15:0]                  pkt_cnt
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, READ, DONE, GAP} state_t;

  state_t            state, state_nxt;
  logic [2:0]        port;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic              sel_ok;
  logic              head_empty;
  logic              head_eop;
  logic [DATA_W-1:0] head_data;
  logic              pop;
  logic              at_max;
  logic              last_word;
  logic              trunc;
  logic              unused_sel_bits;

  assign unused_sel_bits = ^fifo_sel_res_final[6:3];

  assign sel_ok = fifo_sel_res_final[7] &&
                  (int'({29'b0, fifo_sel_res_final[2:0]}) < PORT_NUM);

  // Loop-based mux keeps the locked port index in range for any PORT_NUM.
  always_comb begin
    head_empty = 1'b1;
    head_eop   = 1'b0;
    head_data  = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (port == 3'(i)) begin
        head_empty = fifo_empty[i];
        head_eop   = fifo_rd_eop[i];
        head_data  = fifo_rd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign pop       = (state == READ) && !head_empty && (!out_valid || out_ready);
  assign cnt_inc   = cnt + 1'b1;
  assign at_max    = (cnt_inc == MAX_CNT);
  assign last_word = pop && (head_eop || at_max);
  assign trunc     = pop && !head_eop && at_max;

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = '0;
    fifo_ack   = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: if (sel_ok) state_nxt = READ;
      READ: if (last_word) state_nxt = DONE;
      DONE: state_nxt = GAP;
      GAP:  if (!fifo_sel_res_final[7] || (fifo_sel_res_final[2:0] != port)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (port == 3'(i)) begin
        fifo_rd_en[i] = pop;
        fifo_ack[i]   = (state == DONE);
      end
    end
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      port      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eop   <= 1'b0;
      out_port  <= '0;
      trunc_err <= 1'b0;
    end else begin
      if (state == IDLE && sel_ok) begin
        port <= fifo_sel_res_final[2:0];
        cnt  <= '0;
      end
      if (pop) begin
        cnt       <= cnt_inc;
        out_valid <= 1'b1;
        out_data  <= head_data;
        out_eop   <= head_eop | trunc;
        out_port  <= port;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      trunc_err <= trunc;
    end
  end

`ifdef FIFO_RD_CTRL_STAT_EN
  logic [15:0] pkt_q;
  always_ff @(posedge glb_clk) begin
    if (glb_rst)              pkt_q <= '0;
    else if (state == DONE)   pkt_q <= pkt_q + 16'd1;
  end
  assign pkt_cnt = pkt_q;
`else
  assign pkt_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: FIFO models feed the DUT, expected words/acks
// are queued by the stimulus and checked by an independent monitor.
module tb_fifo_rd_ctrl;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int MW = 4;

  logic            glb_clk = 1'b0;
  logic            glb_rst;
  logic [7:0]      fifo_sel_res_final;
  logic [NP-1:0]   fifo_empty;
  logic [NP*DW-1:0] fifo_rd_data;
  logic [NP-1:0]   fifo_rd_eop;
  logic [NP-1:0]   fifo_rd_en;
  logic [NP-1:0]   fifo_ack;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_eop;
  logic [2:0]      out_port;
  logic            out_ready;
  logic            busy;
  logic            trunc_err;
  logic [15:0]     pkt_cnt;

  fifo_rd_ctrl #(.PORT_NUM(NP), .DATA_W(DW), .MAX_WORDS(MW)) dut (
    .glb_clk(glb_clk), .glb_rst(glb_rst), .fifo_sel_res_final(fifo_sel_res_final),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_eop(fifo_rd_eop),
    .fifo_rd_en(fifo_rd_en), .fifo_ack(fifo_ack), .out_valid(out_valid),
    .out_data(out_data), .out_eop(out_eop), .out_port(out_port), .out_ready(out_ready),
    .busy(busy), .trunc_err(trunc_err), .pkt_cnt(pkt_cnt)
  );

  always #5 glb_clk = ~glb_clk;

  // FIFO models: stimulus owns mem/wr_ptr, the pop process owns rd_ptr.
  logic [DW:0] mem [NP][64];
  int wr_ptr [NP] = '{0, 0, 0, 0};
  int rd_ptr [NP] = '{0, 0, 0, 0};

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i] = (rd_ptr[i] == wr_ptr[i]);
      {fifo_rd_eop[i], fifo_rd_data[i*DW +: DW]} = mem[i][rd_ptr[i] % 64];
    end
  end

  always @(posedge glb_clk) begin
    for (int i = 0; i < NP; i++)
      if (fifo_rd_en[i]) rd_ptr[i] <= rd_ptr[i] + 1;
  end

  // Scoreboard queues.
  logic [35:0] exp_q [$];
  logic [NP-1:0] ack_q [$];
  string       cq_name [$];
  logic [63:0] cq_act [$];
  logic [63:0] cq_exp [$];

  int tests = 0;
  int fails = 0;
  int trunc_seen = 0;
  int cyc = 0;
  int last_pop_cyc = 0;
  int last_pop_port = -1;
  logic        prev_hold = 1'b0;
  logic        prev_rst = 1'b1;
  logic [35:0] prev_word = '0;

  task automatic cmp(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  always @(negedge glb_clk) begin
    while (cq_name.size() > 0)
      cmp(cq_name.pop_front(), cq_act.pop_front(), cq_exp.pop_front());
    if (!glb_rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) cmp("unexpected_word", {28'b0, out_port, out_eop, out_data}, 64'h0);
        else cmp("out_word", {28'b0, out_port, out_eop, out_data}, {28'b0, exp_q.pop_front()});
      end
      if (prev_hold && !prev_rst)
        cmp("hold_stable", {27'b0, out_valid, out_port, out_eop, out_data}, {27'b0, 1'b1, prev_word});
      if (fifo_ack != '0) begin
        if (ack_q.size() == 0) cmp("unexpected_ack", 64'(fifo_ack), 64'h0);
        else cmp("fifo_ack", 64'(fifo_ack), 64'(ack_q.pop_front()));
      end
      if (fifo_rd_en != '0) begin
        cmp("rd_en_onehot", 64'($onehot(fifo_rd_en)), 64'h1);
        cmp("pop_not_empty", 64'(fifo_rd_en & fifo_empty), 64'h0);
        for (int i = 0; i < NP; i++) begin
          if (fifo_rd_en[i]) begin
            if (last_pop_port >= 0 && last_pop_port != i) begin
              tests++;
              if (cyc - last_pop_cyc < 4) begin
                fails++;
                $display("FAIL pkt_spacing: got %0d cycles required >= 4", cyc - last_pop_cyc);
              end
            end
            last_pop_port = i;
            last_pop_cyc = cyc;
          end
        end
      end
      if (trunc_err) trunc_seen++;
    end
    prev_hold = out_valid && !out_ready;
    prev_word = {out_port, out_eop, out_data};
    prev_rst  = glb_rst;
    cyc++;
  end

  task automatic push_chk(input string n, input logic [63:0] a, input logic [63:0] e);
    cq_name.push_back(n);
    cq_act.push_back(a);
    cq_exp.push_back(e);
  endtask

  task automatic tick();
    @(posedge glb_clk);
    #1;
  endtask

  task automatic load(input int p, input logic [DW-1:0] d, input logic eop);
    mem[p][wr_ptr[p] % 64] = {eop, d};
    wr_ptr[p] = wr_ptr[p] + 1;
  endtask

  task automatic expect_word(input int p, input logic [DW-1:0] d, input logic eop);
    exp_q.push_back({3'(p), eop, d});
  endtask

  task automatic drain(input string n, input int maxc);
    int k;
    for (k = 0; k < maxc; k++) begin
      if (exp_q.size() == 0 && ack_q.size() == 0) break;
      tick();
    end
    if (k == maxc) push_chk({n, "_timeout"}, 64'h1, 64'h0);
  endtask

  function automatic logic [15:0] cnt_model(input int n);
`ifdef FIFO_RD_CTRL_STAT_EN
    return 16'(n);
`else
    return 16'd0 + 16'(n * 0);
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pkts = 0;
    int lvl;
    int start;
    int k;
    glb_rst = 1'b1;
    fifo_sel_res_final = 8'd0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    push_chk("rst_outputs", {out_valid, out_eop, out_port, busy, trunc_err, fifo_ack, fifo_rd_en}, 64'h0);
    push_chk("rst_data_cnt", {out_data, pkt_cnt}, 64'h0);
    glb_rst = 1'b0;
    tick();

    // Single packet on port 1.
    load(1, 32'hA100_0001, 1'b0); load(1, 32'hA100_0002, 1'b0); load(1, 32'hA100_0003, 1'b1);
    expect_word(1, 32'hA100_0001, 1'b0); expect_word(1, 32'hA100_0002, 1'b0);
    expect_word(1, 32'hA100_0003, 1'b1);
    ack_q.push_back(4'b0010);
    pkts++;
    fifo_sel_res_final = 8'd129;
    drain("single", 40);
    push_chk("pkt_cnt_1", 64'(pkt_cnt), 64'(cnt_model(pkts)));
    fifo_sel_res_final = 8'd0;
    tick(); tick();
    push_chk("idle_after_1", 64'(busy), 64'h0);

    // Backpressure on port 3.
    load(3, 32'hB300_0001, 1'b0); load(3, 32'hB300_0002, 1'b0); load(3, 32'hB300_0003, 1'b1);
    expect_word(3, 32'hB300_0001, 1'b0); expect_word(3, 32'hB300_0002, 1'b0);
    expect_word(3, 32'hB300_0003, 1'b1);
    ack_q.push_back(4'b1000);
    pkts++;
    fifo_sel_res_final = 8'd131;
    for (k = 0; k < 20 && !out_valid; k++) tick();
    if (k == 20) push_chk("bp_valid_timeout", 64'h1, 64'h0);
    out_ready = 1'b0;
    #2 push_chk("bp_no_pop_a", 64'(fifo_rd_en), 64'h0);
    tick();
    #2 push_chk("bp_no_pop_b", 64'(fifo_rd_en), 64'h0);
    tick();
    out_ready = 1'b1;
    drain("bp", 40);
    push_chk("pkt_cnt_2", 64'(pkt_cnt), 64'(cnt_model(pkts)));
    fifo_sel_res_final = 8'd0;
    tick(); tick();

    // Truncation on port 0: 6 words, no EOP, MAX_WORDS=4.
    for (int i = 1; i <= 6; i++) load(0, 32'hC000_0000 + 32'(i), 1'b0);
    expect_word(0, 32'hC000_0001, 1'b0); expect_word(0, 32'hC000_0002, 1'b0);
    expect_word(0, 32'hC000_0003, 1'b0); expect_word(0, 32'hC000_0004, 1'b1);
    ack_q.push_back(4'b0001);
    pkts++;
    fifo_sel_res_final = 8'd128;
    drain("trunc", 40);
    push_chk("trunc_pulses", 64'(trunc_seen), 64'h1);
    lvl = wr_ptr[0] - rd_ptr[0];
    push_chk("trunc_left", 64'(lvl), 64'h2);

    // Stale code held: stays in GAP, no further pops.
    for (int i = 0; i < 6; i++) tick();
    push_chk("stale_busy", 64'(busy), 64'h1);
    push_chk("stale_left", 64'(wr_ptr[0] - rd_ptr[0]), 64'h2);
    push_chk("trunc_once", 64'(trunc_seen), 64'h1);
    fifo_sel_res_final = 8'd0;
    tick();
    load(2, 32'hD200_0001, 1'b0); load(2, 32'hD200_0002, 1'b1);
    expect_word(2, 32'hD200_0001, 1'b0); expect_word(2, 32'hD200_0002, 1'b1);
    ack_q.push_back(4'b0100);
    pkts++;
    fifo_sel_res_final = 8'd130;
    drain("port2", 40);
    push_chk("pkt_cnt_4", 64'(pkt_cnt), 64'(cnt_model(pkts)));
    fifo_sel_res_final = 8'd0;
    tick(); tick();

    // Valid code with index beyond PORT_NUM.
    fifo_sel_res_final = 8'd134;
    tick(); tick(); tick();
    push_chk("invalid_busy", 64'(busy), 64'h0);
    push_chk("invalid_rd_en", 64'(fifo_rd_en), 64'h0);
    fifo_sel_res_final = 8'd0;
    tick();

    // Reset after the 2nd of 5 words popped; only word 1 is delivered.
    for (int i = 1; i <= 5; i++) load(1, 32'hE100_0000 + 32'(i), (i == 5));
    expect_word(1, 32'hE100_0001, 1'b0);
    start = rd_ptr[1];
    fifo_sel_res_final = 8'd129;
    for (k = 0; k < 20 && rd_ptr[1] != start + 2; k++) tick();
    if (k == 20) push_chk("rst_pop_timeout", 64'h1, 64'h0);
    glb_rst = 1'b1;
    out_ready = 1'b0;
    fifo_sel_res_final = 8'd0;
    tick();
    push_chk("midrst_outputs", {out_valid, out_eop, out_port, busy, trunc_err, fifo_ack, fifo_rd_en}, 64'h0);
    push_chk("midrst_data_cnt", {out_data, pkt_cnt}, 64'h0);
    glb_rst = 1'b0;
    out_ready = 1'b1;
    pkts = 0;
    tick(); tick(); tick();
    push_chk("post_rst_cnt", 64'(pkt_cnt), 64'(cnt_model(pkts)));
    push_chk("post_rst_busy", 64'(busy), 64'h0);
    push_chk("post_rst_left", 64'(wr_ptr[1] - rd_ptr[1]), 64'h3);
    push_chk("words_pending", 64'(exp_q.size()), 64'h0);
    push_chk("acks_pending", 64'(ack_q.size()), 64'h0);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
